// File: rtl/mem_bus_arbiter_n_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_n_if
//   Bundle of every handshake/bus signal around the main-memory arbiter:
//   the NUM_RD read-master request/ready lanes, the write-buffer drain
//   channel and the single main-memory port.
//
//   modport master : the arbiter side (drives ready/pop and the memory port).
//   modport slave  : the environment side (read masters, write buffer, memory).
//
//   Signal groups
//     rd_req_in     [NUM_RD]           per-master level request
//     rd_addr_in    [NUM_RD*ADDR_W]    master i at [i*ADDR_W +: ADDR_W]
//     rd_ready_out  [NUM_RD]           one-cycle line-valid pulse
//     rd_data_out   [LINE_W]           shared read line
//     wb_empty_in / wb_data_in {addr, data[31:0], be[3:0]} / wb_pop_en_out
//     mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
//     mem_rdata_in, mem_wait_in
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_n_if #(
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // read masters
    logic [NUM_RD-1:0]        rd_req_in;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_in;
    logic [NUM_RD-1:0]        rd_ready_out;
    logic [LINE_W-1:0]        rd_data_out;

    // write-buffer drain channel
    logic                     wb_empty_in;
    logic [ADDR_W+35:0]       wb_data_in;
    logic                     wb_pop_en_out;

    // main-memory port
    logic                     mem_req_out;
    logic                     mem_we_out;
    logic [ADDR_W-1:0]        mem_addr_out;
    logic [31:0]              mem_wdata_out;
    logic [3:0]               mem_be_out;
    logic [LINE_W-1:0]        mem_rdata_in;
    logic                     mem_wait_in;

    modport master (
        input  rd_req_in, rd_addr_in, wb_empty_in, wb_data_in,
               mem_rdata_in, mem_wait_in,
        output rd_ready_out, rd_data_out, wb_pop_en_out,
               mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out
    );

    modport slave (
        output rd_req_in, rd_addr_in, wb_empty_in, wb_data_in,
               mem_rdata_in, mem_wait_in,
        input  rd_ready_out, rd_data_out, wb_pop_en_out,
               mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out
    );
endinterface

// File: rtl/mem_bus_arbiter_n.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_n
//   Arbitrates NUM_RD cache-line read masters plus one posted write-buffer
//   drain channel onto a single main-memory port. Read policy is fixed
//   priority (index 0 highest) or round-robin. The winning request is latched
//   at grant time so later input changes cannot disturb a transfer in flight.
//   A starvation guard forces a write-buffer drain after WB_STARVE_MAX read
//   grants taken while the buffer was non-empty.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     bus           mem_bus_arbiter_n_if.master (read lanes, wb drain, memory)
//     busy_out      high whenever a transfer is in progress (state != IDLE)
//     grant_id_out  latched grant; MSB=1 is the write channel, else read index
//
//   Timing: a request seen in IDLE at cycle T puts mem_req_out up at T+1;
//   ready/pop fire in the first cycle with mem_wait_in low. IDLE always sits
//   between two transfers, so grants are at least two cycles apart.
// ----------------------------------------------------------------------------
module mem_bus_arbiter_n #(
    parameter int NUM_RD        = 2,
    parameter int ADDR_W        = 32,
    parameter int LINE_W        = 256,
    parameter int ARB_MODE      = 0,
    parameter int WB_STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_bus_arbiter_n_if.master     bus,
    output logic                    busy_out,
    output logic [$clog2(NUM_RD):0] grant_id_out
);

    localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int GID_W = $clog2(NUM_RD) + 1;
    localparam int CNT_W = $clog2(WB_STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wb_ent_t;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    wb_ent_t                  wb_q, wb_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    // Per-master view of the flat address bus; element i is
    // rd_addr_in[i*ADDR_W +: ADDR_W].
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    assign rd_addr = bus.rd_addr_in;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic             any_rd;
    logic [IDX_W-1:0] fix_win;
    logic [IDX_W-1:0] rr_win;
    logic             rr_found;
    logic [IDX_W-1:0] win;

    assign any_rd = |bus.rd_req_in;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        fix_win = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (bus.rd_req_in[i]) fix_win = IDX_W'(i);
        end
    end

    // Search rr_ptr+1, rr_ptr+2, ... with wrap; the pointer itself is
    // checked last so the previous winner has the lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 1; k <= NUM_RD; k++) begin
            if (!rr_found && bus.rd_req_in[(int'(rr_ptr_q) + k) % NUM_RD]) begin
                rr_found = 1'b1;
                rr_win   = IDX_W'((int'(rr_ptr_q) + k) % NUM_RD);
            end
        end
    end

    assign win = (ARB_MODE == 1) ? rr_win : fix_win;

    // ------------------------------------------------------------------
    // IDLE decision and next state
    // ------------------------------------------------------------------
    logic force_wr;
    logic grant_wr;

    assign force_wr = !bus.wb_empty_in && (cnt_q == CNT_W'(WB_STARVE_MAX));
    // With no read traffic a non-empty buffer drains opportunistically.
    assign grant_wr = force_wr || (!any_rd && !bus.wb_empty_in);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        wb_d     = wb_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d = WRITE;
                    wb_d    = bus.wb_data_in;
                    cnt_d   = '0;
                end else if (any_rd) begin
                    state_d = READ;
                    idx_d   = win;
                    addr_d  = rd_addr[win];
                    if (ARB_MODE == 1) rr_ptr_d = win;
                    // Only reads that bypass a waiting write count toward
                    // starvation; the count saturates at the limit.
                    if (bus.wb_empty_in)
                        cnt_d = '0;
                    else if (cnt_q != CNT_W'(WB_STARVE_MAX))
                        cnt_d = cnt_q + 1'b1;
                end
            end
            READ, WRITE: begin
                // Transfers are never cancelled; they end only on !mem_wait.
                if (!bus.mem_wait_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_ptr_q <= IDX_W'(NUM_RD - 1);
            addr_q   <= '0;
            wb_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wb_q     <= wb_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and latches only, so everything reads
    // zero in IDLE and a reset clears the port in the same instant.
    // ------------------------------------------------------------------
    logic in_rd, in_wr, done;

    assign in_rd = (state_q == READ);
    assign in_wr = (state_q == WRITE);
    assign done  = !bus.mem_wait_in;

    assign bus.mem_req_out   = in_rd || in_wr;
    assign bus.mem_we_out    = in_wr;
    assign bus.mem_addr_out  = in_wr ? wb_q.addr : (in_rd ? addr_q : '0);
    assign bus.mem_wdata_out = in_wr ? wb_q.data : '0;
    assign bus.mem_be_out    = in_wr ? wb_q.be   : '0;

    assign bus.rd_ready_out  = (in_rd && done) ? (NUM_RD'(1) << idx_q) : '0;
    assign bus.rd_data_out   = in_rd ? bus.mem_rdata_in : '0;
    assign bus.wb_pop_en_out = in_wr && done;

    assign busy_out     = in_rd || in_wr;
    assign grant_id_out = in_wr ? (GID_W'(1) << (GID_W - 1)) :
                          (in_rd ? GID_W'(idx_q) : '0);

endmodule

// File: tb/tb_mem_bus_arbiter_n.sv
module tb_mem_bus_arbiter_n;
    localparam int N   = 3;
    localparam int AW  = 16;
    localparam int LW  = 32;
    localparam int GW  = 3;
    localparam int WBW = AW + 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // shared stimulus for both DUTs
    logic [N-1:0]    s_req;
    logic [N*AW-1:0] s_addr;
    logic            s_wbe;
    logic [WBW-1:0]  s_wbd;
    logic [LW-1:0]   s_rdata;
    logic            s_wait;

    mem_bus_arbiter_n_if #(.NUM_RD(N), .ADDR_W(AW), .LINE_W(LW)) bf ();
    mem_bus_arbiter_n_if #(.NUM_RD(N), .ADDR_W(AW), .LINE_W(LW)) br ();

    assign bf.rd_req_in = s_req;   assign br.rd_req_in = s_req;
    assign bf.rd_addr_in = s_addr; assign br.rd_addr_in = s_addr;
    assign bf.wb_empty_in = s_wbe; assign br.wb_empty_in = s_wbe;
    assign bf.wb_data_in = s_wbd;  assign br.wb_data_in = s_wbd;
    assign bf.mem_rdata_in = s_rdata; assign br.mem_rdata_in = s_rdata;
    assign bf.mem_wait_in = s_wait;   assign br.mem_wait_in = s_wait;

    logic          busy_f, busy_r;
    logic [GW-1:0] gid_f, gid_r;

    mem_bus_arbiter_n #(.NUM_RD(N), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(0), .WB_STARVE_MAX(2))
        u_fix (.clk(clk), .rst_n(rst_n), .bus(bf.master), .busy_out(busy_f), .grant_id_out(gid_f));
    mem_bus_arbiter_n #(.NUM_RD(N), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(1), .WB_STARVE_MAX(3))
        u_rr (.clk(clk), .rst_n(rst_n), .bus(br.master), .busy_out(busy_r), .grant_id_out(gid_r));

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic [N-1:0]  ready;
        logic          pop;
        logic          busy;
        logic [GW-1:0] gid;
        logic [LW-1:0] rdata;
    } out_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    out_t snap [2];

    // ---------------- reference model (transaction view) ----------------
    // m_gnt: -1 idle, 0..N-1 read master being served, N = write drain
    int             m_gnt  [2];
    logic [AW-1:0]  m_addr [2];
    logic [WBW-1:0] m_wb   [2];
    int             m_ptr  [2];
    int             m_cnt  [2];
    int             MAXC   [2] = '{2, 3};
    int             RRM    [2] = '{0, 1};

    task automatic model_reset(int d);
        m_gnt[d] = -1; m_ptr[d] = N - 1; m_cnt[d] = 0;
        m_addr[d] = '0; m_wb[d] = '0;
    endtask

    function automatic out_t model_out(int d);
        out_t o;
        o = '0;
        if (rst_n && m_gnt[d] >= 0) begin
            o.req  = 1'b1;
            o.busy = 1'b1;
            if (m_gnt[d] == N) begin
                o.we    = 1'b1;
                o.addr  = m_wb[d][WBW-1 -: AW];
                o.wdata = m_wb[d][35:4];
                o.be    = m_wb[d][3:0];
                o.pop   = !s_wait;
                o.gid   = 3'b100;
            end else begin
                o.addr  = m_addr[d];
                o.ready = s_wait ? '0 : (N'(1) << m_gnt[d]);
                o.gid   = GW'(m_gnt[d]);
                o.rdata = s_rdata;
            end
        end
        return o;
    endfunction

    task automatic model_step(int d);
        int w;
        if (!rst_n) begin
            model_reset(d);
        end else if (m_gnt[d] < 0) begin
            w = -1;
            if (RRM[d] == 1) begin
                for (int k = 1; k <= N; k++)
                    if (w < 0 && s_req[(m_ptr[d] + k) % N]) w = (m_ptr[d] + k) % N;
            end else begin
                for (int i = 0; i < N; i++)
                    if (w < 0 && s_req[i]) w = i;
            end
            if (!s_wbe && (m_cnt[d] == MAXC[d] || w < 0)) begin
                m_gnt[d] = N; m_wb[d] = s_wbd; m_cnt[d] = 0;
            end else if (w >= 0) begin
                m_gnt[d] = w; m_addr[d] = s_addr[w*AW +: AW];
                if (RRM[d] == 1) m_ptr[d] = w;
                m_cnt[d] = s_wbe ? 0 : ((m_cnt[d] + 1 > MAXC[d]) ? MAXC[d] : m_cnt[d] + 1);
            end
        end else if (!s_wait) begin
            m_gnt[d] = -1;
        end
    endtask

    function automatic out_t get_out(int d);
        out_t o;
        if (d == 0) begin
            o.req = bf.mem_req_out; o.we = bf.mem_we_out; o.addr = bf.mem_addr_out;
            o.wdata = bf.mem_wdata_out; o.be = bf.mem_be_out; o.ready = bf.rd_ready_out;
            o.pop = bf.wb_pop_en_out; o.busy = busy_f; o.gid = gid_f; o.rdata = bf.rd_data_out;
        end else begin
            o.req = br.mem_req_out; o.we = br.mem_we_out; o.addr = br.mem_addr_out;
            o.wdata = br.mem_wdata_out; o.be = br.mem_be_out; o.ready = br.rd_ready_out;
            o.pop = br.wb_pop_en_out; o.busy = busy_r; o.gid = gid_r; o.rdata = br.rd_data_out;
        end
        return o;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, move off edge.
    task automatic cycle();
        out_t e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            snap[d] = get_out(d);
            e = model_out(d);
            chk(d == 0 ? "model_fix" : "model_rr", 128'(snap[d]), 128'(e));
            chk(d == 0 ? "onehot_fix" : "onehot_rr",
                128'($countones(snap[d].ready) + int'(snap[d].pop) <= 1), 128'(1));
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table (fixed DUT) ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic          wbe;
        logic          wt;
        logic          e_req;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic [N-1:0]  e_ready;
        logic          e_pop;
        logic [GW-1:0] e_gid;
    } vec_t;

    vec_t vt [17];
    int   rr_order [$];

    initial begin
        //      req     wbe  wt   req we  addr      wdata          rdy     pop gid
        vt[0]  = '{3'b001, 0, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[1]  = '{3'b001, 0, 0,  1, 0, 16'h1000, 32'h0,         3'b001, 0, 3'd0};
        vt[2]  = '{3'b001, 0, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[3]  = '{3'b001, 0, 0,  1, 0, 16'h1000, 32'h0,         3'b001, 0, 3'd0};
        vt[4]  = '{3'b001, 0, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[5]  = '{3'b001, 0, 0,  1, 1, 16'h0100, 32'hDEADBEEF,  3'b000, 1, 3'b100};
        vt[6]  = '{3'b001, 0, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[7]  = '{3'b001, 0, 0,  1, 0, 16'h1000, 32'h0,         3'b001, 0, 3'd0};
        vt[8]  = '{3'b011, 1, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[9]  = '{3'b011, 1, 0,  1, 0, 16'h1000, 32'h0,         3'b001, 0, 3'd0};
        vt[10] = '{3'b011, 1, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[11] = '{3'b011, 1, 0,  1, 0, 16'h1000, 32'h0,         3'b001, 0, 3'd0};
        vt[12] = '{3'b110, 1, 0,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[13] = '{3'b110, 1, 0,  1, 0, 16'h2000, 32'h0,         3'b010, 0, 3'd1};
        vt[14] = '{3'b100, 1, 1,  0, 0, 16'h0000, 32'h0,         3'b000, 0, 3'd0};
        vt[15] = '{3'b100, 1, 1,  1, 0, 16'h3000, 32'h0,         3'b000, 0, 3'd2};
        vt[16] = '{3'b100, 1, 0,  1, 0, 16'h3000, 32'h0,         3'b100, 0, 3'd2};

        model_reset(0); model_reset(1);
        rst_n = 1'b0; s_req = '0; s_addr = '0; s_wbe = 1'b1; s_wbd = '0;
        s_rdata = '0; s_wait = 1'b0;
        cycle(); cycle();
        chk("reset_state", 128'(snap[0]), 128'(0));
        rst_n = 1'b1;

        // nothing to do: stays idle
        repeat (4) cycle();
        chk("idle_busy", 128'(snap[0].busy), 128'(0));
        chk("idle_outs", 128'(snap[1]), 128'(0));

        // table: starvation guard, fixed priority, wait stretch
        rst_pulse();
        s_addr = {16'h3000, 16'h2000, 16'h1000};
        s_wbd  = {16'h0100, 32'hDEADBEEF, 4'hF};
        for (int i = 0; i < 17; i++) begin
            s_req = vt[i].req; s_wbe = vt[i].wbe; s_wait = vt[i].wt;
            s_rdata = LW'($urandom);
            cycle();
            chk($sformatf("vec%0d_ctl", i),
                128'({snap[0].req, snap[0].we, snap[0].addr, snap[0].ready, snap[0].pop, snap[0].gid}),
                128'({vt[i].e_req, vt[i].e_we, vt[i].e_addr, vt[i].e_ready, vt[i].e_pop, vt[i].e_gid}));
            chk($sformatf("vec%0d_wdata", i), 128'(snap[0].wdata), 128'(vt[i].e_wdata));
        end

        // RR alternation; fixed DUT alternates mem_req with master 0 only
        rst_pulse();
        s_req = 3'b011; s_wbe = 1'b1; s_wait = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_rdata = LW'($urandom);
            cycle();
            chk("fix_alt_req", 128'(snap[0].req), 128'(i % 2));
            if (snap[1].ready != '0) begin
                rr_order.push_back(int'(snap[1].gid));
                chk("rr_rdata", 128'(snap[1].rdata), 128'(s_rdata));
            end
        end
        chk("rr_count", 128'(rr_order.size()), 128'(4));
        for (int k = 0; k < rr_order.size() && k < 4; k++)
            chk("rr_order", 128'(rr_order[k]), 128'(k % 2));

        // long wait with request/address changed mid-transfer
        rst_pulse();
        s_req = 3'b001; s_addr = {16'h3000, 16'h2000, 16'hAAAA}; s_wait = 1'b1;
        cycle();
        s_req = 3'b000; s_addr = {16'h3000, 16'h2000, 16'h5555};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("wait_addr", 128'(snap[0].addr), 128'(16'hAAAA));
            chk("wait_noready", 128'(snap[0].ready), 128'(0));
        end
        s_wait = 1'b0;
        cycle();
        chk("wait_ready", 128'({snap[0].ready, snap[0].addr}), 128'({3'b001, 16'hAAAA}));
        cycle();
        chk("wait_single", 128'(snap[0].ready), 128'(0));

        // reset in the middle of a write: no pop, write re-issued afterwards
        rst_pulse();
        s_req = '0; s_wbe = 1'b0; s_wbd = {16'h0200, 32'hCAFEF00D, 4'h3}; s_wait = 1'b1;
        cycle();
        cycle();
        chk("wr_pending", 128'({snap[0].we, snap[0].pop}), 128'({1'b1, 1'b0}));
        rst_n = 1'b0;
        cycle();
        chk("wr_abort", 128'(snap[0]), 128'(0));
        rst_n = 1'b1; s_wait = 1'b0;
        cycle();
        cycle();
        chk("wr_reissue", 128'({snap[0].we, snap[0].addr, snap[0].wdata, snap[0].pop}),
            128'({1'b1, 16'h0200, 32'hCAFEF00D, 1'b1}));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s_req   = N'($urandom_range(0, 7));
            s_addr  = {16'($urandom), 16'($urandom), 16'($urandom)};
            s_wbe   = ($urandom_range(0, 2) != 0);
            s_wbd   = {20'($urandom), 32'($urandom)};
            s_rdata = LW'($urandom);
            s_wait  = ($urandom_range(0, 3) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
